// File: rtl/gate_tester2.sv
// gate_tester2: drives x1x0 through 00..11, samples the synchronised gate output
// after a settle period and records per-vector mismatches against EXPECTED.
module gate_tester2 #(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] EXPECTED      = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       z0,
  output logic       x0,
  output logic       x1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
);
  localparam int CW = (SETTLE_CYCLES < 3) ? 2 : $clog2(SETTLE_CYCLES);
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("gate_tester2: SETTLE_CYCLES must be >= 3");
  end
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] v_q, v_d, x_q, x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0] fail_q, fail_d, fail_hit;
  logic zm_q, zs_q;
  // the compare includes the bit being set this cycle so pass reflects all four vectors
  assign fail_hit = fail_q | ((zs_q != EXPECTED[v_q]) ? (4'b0001 << v_q) : 4'b0000);
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = SETTLE;
        v_d     = 2'd0;
        x_d     = 2'd0;
        cnt_d   = '0;
        fail_d  = 4'b0000;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
      SETTLE: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        fail_d = fail_hit;
        if (v_q != 2'd3) begin
          state_d = SETTLE;
          v_d     = v_q + 2'd1;
          x_d     = v_q + 2'd1;
          cnt_d   = '0;
        end else begin
          state_d = DONE;
          x_d     = 2'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_hit == 4'b0000);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= 2'd0;
      x_q     <= 2'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 4'b0000;
      zm_q    <= 1'b0;
      zs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      zm_q    <= z0;
      zs_q    <= zm_q;
    end
  end
  assign {x1, x0} = x_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_vec = fail_q;
endmodule

// File: tb/tb_gate_tester2.sv
// tb_gate_tester2: directed runs of gate_tester2 against modelled gates, with a
// scoreboard of expected {pass, fail_vec} pushed at start and popped at done.
module tb_gate_tester2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic xa0, xa1, za, busy_a, done_a, pass_a;
  logic xb0, xb1, zb, busy_b, done_b, pass_b;
  logic [3:0] fv_a, fv_b;
  int mode = 0;
  int checks = 0, errors = 0;
  logic [4:0] sb[$];
  always #5 clk = ~clk;
  function automatic logic gate(input int m, input logic a1, input logic a0);
    case (m)
      0: return a1 | a0;
      1: return a1 & a0;
      2: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction
  function automatic logic [3:0] truth(input int m);
    logic [3:0] r;
    logic [1:0] vv;
    for (int i = 0; i < 4; i++) begin
      vv = 2'(i);
      r[i] = gate(m, vv[1], vv[0]);
    end
    return r;
  endfunction
  assign za = gate(mode, xa1, xa0);
  assign zb = gate(mode, xb1, xb0);
  gate_tester2 #(.SETTLE_CYCLES(4), .EXPECTED(4'b1110)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .z0(za), .x0(xa0), .x1(xa1),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_vec(fv_a));
  gate_tester2 #(.SETTLE_CYCLES(4), .EXPECTED(4'b1000)) u_dut_and (
    .clk(clk), .rst_n(rst_n), .start(start), .z0(zb), .x0(xb0), .x1(xb1),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_vec(fv_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_x"}, {xa1, xa0}, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pass"}, pass_a, 0);
    chk({tag, "_fv"}, fv_a, 0);
  endtask
  // inj: 0 plain run, 1 extra start pulse mid-run, 2 reset mid-run
  task automatic run(input int m, input int inj, input bit chk_x);
    logic [3:0] ef;
    logic [4:0] e;
    bit got;
    mode = m;
    ef = truth(m) ^ 4'b1110;
    sb.push_back({ef == 4'b0000, ef});
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_busy", busy_a, 1);
    chk("start_done", done_a, 0);
    chk("start_fv", fv_a, 0);
    chk("start_x", {xa1, xa0}, 0);
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (inj == 1) start = (k == 7);
      if (inj == 2 && k == 10) begin
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        void'(sb.pop_front());
        @(negedge clk) rst_n = 1'b1;
        return;
      end
      if (done_a) begin
        got = 1'b1;
        chk("done_edge", k, 20);
      end else if (chk_x) begin
        chk("x_vec", {xa1, xa0}, k / 5);
        chk("run_busy", busy_a, 1);
      end
    end
    chk("done_seen", got, 1);
    if (got) begin
      e = sb.pop_front();
      chk("pass", pass_a, e[4]);
      chk("fail_vec", fv_a, e[3:0]);
      chk("end_busy", busy_a, 0);
      chk("end_x", {xa1, xa0}, 0);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 chk_idle_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_idle_outputs("idle");
    run(0, 0, 1'b1);
    run(2, 0, 1'b0);
    chk("tie0_fv", fv_a, 4'b1110);
    run(3, 0, 1'b0);
    chk("tie1_fv", fv_a, 4'b0001);
    run(1, 0, 1'b0);
    chk("and_fv", fv_a, 4'b0110);
    chk("and_b_pass", pass_b, 1);
    chk("and_b_fv", fv_b, 4'b0000);
    run(0, 1, 1'b1);
    run(0, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk_idle_outputs("after_reset");
    run(0, 0, 1'b1);
    run(2, 0, 1'b0);
    chk("done_hold_pass", pass_a, 0);
    chk("done_hold_done", done_a, 1);
    run(0, 0, 1'b0);
    chk("restart_pass", pass_a, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
